// File: rtl/mem_ctrl_pkg.sv
// Shared types and constants for the data-memory port arbiter.
// Holds the controller state encoding and the default memory geometry.
package mem_ctrl_pkg;

  typedef enum logic [2:0] {
    BOOT,
    LOAD,
    IDLE,
    ACCESS,
    FLUSH,
    HALT
  } state_t;

  localparam int DEF_ADDR_W = 8;
  localparam int DEF_DATA_W = 32;
  localparam int MEM_WORDS  = 128;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: first eligible index strictly after ptr,
// wrapping; the pointer register itself lives in the parent.
module rr_arbiter #(
  parameter int N_REQ = 2,
  parameter int ID_W  = 3
) (
  input  logic [N_REQ-1:0] eligible,
  input  logic [ID_W-1:0]  ptr,
  output logic [N_REQ-1:0] winner,
  output logic [ID_W-1:0]  winner_idx,
  output logic             any_valid
);

  logic [N_REQ-1:0] above_ptr;
  logic [N_REQ-1:0] upper;
  logic [N_REQ-1:0] pick;

  genvar gi;
  generate
    for (gi = 0; gi < N_REQ; gi++) begin : g_above
      assign above_ptr[gi] = (ID_W'(gi) > ptr);
    end
  endgenerate

  // Prefer indices above the pointer; fall back to the wrapped set.
  assign upper     = eligible & above_ptr;
  assign pick      = (|upper) ? upper : eligible;
  assign any_valid = |eligible;

  always_comb begin
    winner     = '0;
    winner_idx = '0;
    for (int i = N_REQ - 1; i >= 0; i--) begin
      if (pick[i]) begin
        winner     = '0;
        winner[i]  = 1'b1;
        winner_idx = ID_W'(i);
      end
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one single-port data memory between N_REQ engines: load pulse after
// reset, round-robin read/write access, then a dump pulse once all engines finish.
module mem_port_arbiter
  import mem_ctrl_pkg::*;
#(
  parameter int N_REQ  = 2,
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DATA_W = DEF_DATA_W,
  parameter int ID_W   = 3
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [N_REQ-1:0]          req,
  input  logic [N_REQ-1:0]          req_we,
  input  logic [N_REQ*ADDR_W-1:0]   req_addr,
  input  logic [N_REQ*DATA_W-1:0]   req_wdata,
  input  logic [N_REQ-1:0]          fin,
  output logic [N_REQ-1:0]          gnt,
  output logic [DATA_W-1:0]         rdata,
  output logic                      rvalid,
  output logic [ID_W-1:0]           rid,
  output logic                      busy,
  output logic                      halted,
  output logic                      mem_load,
  output logic [ADDR_W-1:0]         mem_addr,
  output logic [ADDR_W-1:0]         mem_write_addr,
  output logic [DATA_W-1:0]         mem_wdata,
  output logic                      mem_we,
  output logic                      mem_read,
  output logic                      mem_done,
  input  logic [DATA_W-1:0]         mem_rdata
);

  state_t              state_reg, state_next;
  logic [ID_W-1:0]     ptr_reg, ptr_next;
  logic [ID_W-1:0]     cur_id_reg, cur_id_next;
  logic [N_REQ-1:0]    fin_reg, fin_next;
  logic [N_REQ-1:0]    gnt_reg, gnt_next;
  logic [DATA_W-1:0]   rdata_reg, rdata_next;
  logic                rvalid_reg, rvalid_next;
  logic [ID_W-1:0]     rid_reg, rid_next;
  logic                busy_reg, busy_next;
  logic                halted_reg, halted_next;
  logic                load_reg, load_next;
  logic                done_reg, done_next;
  logic [ADDR_W-1:0]   addr_reg, addr_next;
  logic [DATA_W-1:0]   wdata_reg, wdata_next;
  logic                we_reg, we_next;
  logic                read_reg, read_next;

  logic [N_REQ-1:0]    eligible;
  logic [N_REQ-1:0]    win_onehot;
  logic [ID_W-1:0]     win_idx;
  logic                win_any;
  logic                sel_we;
  logic [ADDR_W-1:0]   sel_addr;
  logic [DATA_W-1:0]   sel_wdata;

  // Eligibility uses the pre-edge sticky finish bits, so a last request
  // arriving together with its fin is still served.
  assign eligible = req & ~fin_reg;

  rr_arbiter #(
    .N_REQ (N_REQ),
    .ID_W  (ID_W)
  ) u_rr (
    .eligible   (eligible),
    .ptr        (ptr_reg),
    .winner     (win_onehot),
    .winner_idx (win_idx),
    .any_valid  (win_any)
  );

  always_comb begin
    sel_we    = 1'b0;
    sel_addr  = '0;
    sel_wdata = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (win_onehot[i]) begin
        sel_we    = req_we[i];
        sel_addr  = req_addr[i*ADDR_W +: ADDR_W];
        sel_wdata = req_wdata[i*DATA_W +: DATA_W];
      end
    end
  end

  always_comb begin
    state_next  = state_reg;
    ptr_next    = ptr_reg;
    cur_id_next = cur_id_reg;
    fin_next    = fin_reg;
    gnt_next    = '0;
    rdata_next  = rdata_reg;
    rvalid_next = 1'b0;
    rid_next    = rid_reg;
    busy_next   = 1'b0;
    halted_next = halted_reg;
    load_next   = 1'b0;
    done_next   = 1'b0;
    addr_next   = addr_reg;
    wdata_next  = wdata_reg;
    we_next     = 1'b0;
    read_next   = 1'b0;

    if (state_reg != HALT) begin
      fin_next = fin_reg | fin;
    end

    case (state_reg)
      BOOT: begin
        state_next = LOAD;
        load_next  = 1'b1;
      end
      LOAD: begin
        state_next = IDLE;
      end
      IDLE: begin
        if (win_any) begin
          state_next  = ACCESS;
          ptr_next    = win_idx;
          cur_id_next = win_idx;
          gnt_next    = win_onehot;
          addr_next   = sel_addr;
          wdata_next  = sel_wdata;
          we_next     = sel_we;
          read_next   = ~sel_we;
          busy_next   = 1'b1;
        end else if (&fin_reg) begin
          state_next = FLUSH;
          done_next  = 1'b1;
        end
      end
      ACCESS: begin
        // Memory commits a write on this same edge; a read is captured here.
        if (read_reg) begin
          rdata_next  = mem_rdata;
          rvalid_next = 1'b1;
          rid_next    = cur_id_reg;
        end
        state_next = IDLE;
      end
      FLUSH: begin
        state_next  = HALT;
        halted_next = 1'b1;
      end
      HALT: begin
        state_next = HALT;
      end
      default: begin
        state_next = BOOT;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg  <= BOOT;
      ptr_reg    <= ID_W'(N_REQ - 1);
      cur_id_reg <= '0;
      fin_reg    <= '0;
      gnt_reg    <= '0;
      rdata_reg  <= '0;
      rvalid_reg <= 1'b0;
      rid_reg    <= '0;
      busy_reg   <= 1'b0;
      halted_reg <= 1'b0;
      load_reg   <= 1'b0;
      done_reg   <= 1'b0;
      addr_reg   <= '0;
      wdata_reg  <= '0;
      we_reg     <= 1'b0;
      read_reg   <= 1'b0;
    end else begin
      state_reg  <= state_next;
      ptr_reg    <= ptr_next;
      cur_id_reg <= cur_id_next;
      fin_reg    <= fin_next;
      gnt_reg    <= gnt_next;
      rdata_reg  <= rdata_next;
      rvalid_reg <= rvalid_next;
      rid_reg    <= rid_next;
      busy_reg   <= busy_next;
      halted_reg <= halted_next;
      load_reg   <= load_next;
      done_reg   <= done_next;
      addr_reg   <= addr_next;
      wdata_reg  <= wdata_next;
      we_reg     <= we_next;
      read_reg   <= read_next;
    end
  end

  assign gnt            = gnt_reg;
  assign rdata          = rdata_reg;
  assign rvalid         = rvalid_reg;
  assign rid            = rid_reg;
  assign busy           = busy_reg;
  assign halted         = halted_reg;
  assign mem_load       = load_reg;
  assign mem_addr       = addr_reg;
  assign mem_write_addr = addr_reg;
  assign mem_wdata      = wdata_reg;
  assign mem_we         = we_reg;
  assign mem_read       = read_reg;
  assign mem_done       = done_reg;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Randomised scoreboard bench for mem_port_arbiter with a transaction-level
// reference model and a behavioural memory attached to the DUT.
module tb_mem_port_arbiter;
  import mem_ctrl_pkg::*;

  localparam int N  = 3;
  localparam int AW = 8;
  localparam int DW = 32;
  localparam int IW = 3;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic            rst;
  logic [N-1:0]    req, req_we, fin;
  logic [N*AW-1:0] req_addr;
  logic [N*DW-1:0] req_wdata;
  logic [N-1:0]    gnt;
  logic [DW-1:0]   rdata;
  logic            rvalid;
  logic [IW-1:0]   rid;
  logic            busy, halted, mem_load, mem_we, mem_read, mem_done;
  logic [AW-1:0]   mem_addr, mem_write_addr;
  logic [DW-1:0]   mem_wdata, mem_rdata;

  mem_port_arbiter #(.N_REQ(N), .ADDR_W(AW), .DATA_W(DW), .ID_W(IW)) dut (
    .clk(clk), .rst(rst), .req(req), .req_we(req_we), .req_addr(req_addr),
    .req_wdata(req_wdata), .fin(fin), .gnt(gnt), .rdata(rdata), .rvalid(rvalid),
    .rid(rid), .busy(busy), .halted(halted), .mem_load(mem_load),
    .mem_addr(mem_addr), .mem_write_addr(mem_write_addr), .mem_wdata(mem_wdata),
    .mem_we(mem_we), .mem_read(mem_read), .mem_done(mem_done), .mem_rdata(mem_rdata)
  );

  function automatic logic [DW-1:0] init_word(input int i);
    return 32'hC0DE_0000 | DW'(i);
  endfunction

  // Behavioural memory: load initialises, write commits on the edge ending ACCESS.
  logic [DW-1:0] dev_mem [MEM_WORDS];
  always @(posedge clk) begin
    if (mem_load) begin
      for (int i = 0; i < MEM_WORDS; i++) dev_mem[i] <= init_word(i);
    end else if (mem_we) begin
      dev_mem[mem_write_addr[6:0]] <= mem_wdata;
    end
  end
  assign mem_rdata = mem_read ? dev_mem[mem_addr[6:0]] : '0;

  typedef struct {
    int          id;
    logic        we;
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
  } txn_t;

  typedef struct {
    int          id;
    int          edge_n;
    logic        we;
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
  } exp_t;

  txn_t txq[$];
  exp_t gnt_q[$];
  exp_t rd_q[$];
  logic [N-1:0] active;
  logic [N-1:0] fin_given;
  int gnt_count [N];

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic fail_event(input string name, input string what);
    n_checks++;
    n_fail++;
    $display("FAIL %s: %s (t=%0t)", name, what, $time);
  endtask

  task automatic push_txn(input int id, input logic we, input logic [AW-1:0] addr, input logic [DW-1:0] data);
    txn_t t;
    t.id = id; t.we = we; t.addr = addr; t.data = data;
    txq.push_back(t);
  endtask

  // Requester drivers: hold each transaction until its gnt is seen.
  initial begin
    txn_t t;
    req = '0; req_we = '0; req_addr = '0; req_wdata = '0; active = '0;
    forever begin
      @(negedge clk);
      for (int i = 0; i < N; i++) begin
        if (rst !== 1'b1) begin
          active[i] = 1'b0;
        end else begin
          if (active[i] && gnt[i]) active[i] = 1'b0;
          if (!active[i]) begin
            for (int j = 0; j < txq.size(); j++) begin
              if (txq[j].id == i) begin
                t = txq[j];
                txq.delete(j);
                active[i] = 1'b1;
                req_we[i] = t.we;
                req_addr[i*AW +: AW] = t.addr;
                req_wdata[i*DW +: DW] = t.data;
                break;
              end
            end
          end
        end
        req[i] = active[i];
      end
    end
  end

  // Reference model: edges counted from reset release, arbitration from the
  // third edge, one access every two edges, round robin over pending requests.
  int           n_edge = 0;
  int           next_arb = 3;
  int           flush_edge = -1;
  int           ptr_m = N - 1;
  logic [N-1:0] fin_seen = '0;
  logic         exp_load = 1'b0, exp_busy = 1'b0, exp_done = 1'b0, exp_halted = 1'b0;
  logic [DW-1:0] ref_mem [MEM_WORDS];

  initial begin
    logic [N-1:0] elig;
    int c;
    exp_t e;
    forever begin
      @(posedge clk);
      if (rst !== 1'b1) begin
        n_edge = 0; next_arb = 3; flush_edge = -1; ptr_m = N - 1; fin_seen = '0;
        exp_load = 1'b0; exp_busy = 1'b0; exp_done = 1'b0; exp_halted = 1'b0;
        gnt_q.delete();
        rd_q.delete();
      end else begin
        n_edge++;
        exp_load   = (n_edge == 1);
        exp_busy   = 1'b0;
        exp_done   = 1'b0;
        exp_halted = (flush_edge >= 0) && (n_edge > flush_edge);
        if (n_edge == 1) begin
          for (int i = 0; i < MEM_WORDS; i++) ref_mem[i] = init_word(i);
        end
        if (flush_edge < 0 && n_edge >= next_arb) begin
          elig = req & ~fin_seen;
          if (elig != '0) begin
            c = ptr_m;
            for (int k = 1; k <= N; k++) begin
              c = (ptr_m + k) % N;
              if (elig[c]) break;
            end
            ptr_m    = c;
            e.id     = c;
            e.edge_n = n_edge;
            e.we     = req_we[c];
            e.addr   = req_addr[c*AW +: AW];
            if (e.we) begin
              e.data = req_wdata[c*DW +: DW];
              ref_mem[e.addr[6:0]] = e.data;
            end else begin
              e.data = ref_mem[e.addr[6:0]];
              rd_q.push_back(e);
            end
            gnt_q.push_back(e);
            next_arb = n_edge + 2;
            exp_busy = 1'b1;
          end else if (&fin_seen) begin
            flush_edge = n_edge;
            exp_done   = 1'b1;
          end
        end
        fin_seen = fin_seen | fin;
      end
    end
  end

  // Monitor: compares DUT outputs against the model on every falling edge.
  initial begin
    exp_t e;
    for (int i = 0; i < N; i++) gnt_count[i] = 0;
    forever begin
      @(negedge clk);
      if (rst === 1'b1 && n_edge > 0) begin
        check("mem_load", mem_load, exp_load);
        check("busy", busy, exp_busy);
        check("mem_done", mem_done, exp_done);
        check("halted", halted, exp_halted);
        check("we_read_excl", mem_we & mem_read, 1'b0);
        for (int i = 0; i < N; i++) if (gnt[i]) gnt_count[i]++;
        if (gnt != '0) begin
          if (gnt_q.size() == 0) begin
            fail_event("gnt_unexpected", $sformatf("got gnt=%b, expected none", gnt));
          end else begin
            e = gnt_q.pop_front();
            check("gnt", gnt, N'(1) << e.id);
            check("gnt_edge", n_edge, e.edge_n);
            check("mem_addr", mem_addr, e.addr);
            check("mem_write_addr", mem_write_addr, e.addr);
            check("mem_we", mem_we, e.we);
            check("mem_read", mem_read, !e.we);
            if (e.we) check("mem_wdata", mem_wdata, e.data);
          end
        end else if (gnt_q.size() > 0 && gnt_q[0].edge_n <= n_edge) begin
          fail_event("gnt_missing", $sformatf("got none, expected gnt to requester %0d", gnt_q[0].id));
          void'(gnt_q.pop_front());
        end
        if (rvalid) begin
          if (rd_q.size() == 0) begin
            fail_event("rvalid_unexpected", $sformatf("got rvalid rid=%0d, expected none", rid));
          end else begin
            e = rd_q.pop_front();
            check("rid", rid, e.id);
            check("rdata", rdata, e.data);
            check("rvalid_edge", n_edge, e.edge_n + 1);
          end
        end else if (rd_q.size() > 0 && rd_q[0].edge_n + 1 <= n_edge) begin
          fail_event("rvalid_missing", $sformatf("got none, expected read for requester %0d", rd_q[0].id));
          void'(rd_q.pop_front());
        end
      end
    end
  end

  function automatic bit drained();
    return (txq.size() == 0) && ((active & ~fin_given) == '0) &&
           (gnt_q.size() == 0) && (rd_q.size() == 0);
  endfunction

  task automatic wait_drain(input int budget);
    int cyc = 0;
    while (cyc < budget && !drained()) begin
      @(negedge clk);
      cyc++;
    end
    check("drain_done", drained(), 1'b1);
  endtask

  task automatic wait_gnt(input int id, input int budget);
    int cyc = 0;
    @(negedge clk);
    while (cyc < budget && !gnt[id]) begin
      @(negedge clk);
      cyc++;
    end
    check("wait_gnt", gnt[id], 1'b1);
  endtask

  initial begin
    int base0, base2, cyc;
    rst = 1'b0; fin = '0; fin_given = '0;
    repeat (3) @(negedge clk);
    #1;
    check("reset_state", {gnt, rdata, rvalid, rid, busy, halted, mem_load, mem_addr,
          mem_write_addr, mem_wdata, mem_we, mem_read, mem_done}, '0);
    @(negedge clk);
    rst = 1'b1;

    // Directed write then read on requester 0; held off through BOOT/LOAD.
    push_txn(0, 1'b1, 8'h05, 32'hDEAD_BEEF);
    push_txn(0, 1'b0, 8'h05, '0);
    wait_drain(200);
    check("directed_rdata", rdata, 32'hDEAD_BEEF);
    check("directed_rid", rid, 0);

    // Two requesters held back to back.
    @(posedge clk); #1;
    for (int k = 0; k < 4; k++) begin
      push_txn(0, 1'($urandom_range(0, 1)), AW'($urandom_range(0, 15)), $urandom);
      push_txn(1, 1'($urandom_range(0, 1)), AW'($urandom_range(0, 15)), $urandom);
    end
    wait_drain(200);

    // Random traffic on all requesters.
    repeat (150) begin
      @(posedge clk); #1;
      for (int i = 0; i < N; i++)
        if ($urandom_range(0, 99) < 30)
          push_txn(i, 1'($urandom_range(0, 1)), AW'($urandom_range(0, 15)), $urandom);
    end
    wait_drain(2000);

    // Reset in the middle of an access.
    @(posedge clk); #1;
    push_txn(1, 1'b0, 8'h03, '0);
    cyc = 0;
    @(negedge clk);
    while (cyc < 50 && !busy) begin
      @(negedge clk);
      cyc++;
    end
    check("busy_before_reset", busy, 1'b1);
    #2 rst = 1'b0;
    #1;
    check("reset_async", {gnt, rdata, rvalid, rid, busy, halted, mem_load, mem_addr,
          mem_write_addr, mem_wdata, mem_we, mem_read, mem_done}, '0);
    txq.delete();
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(posedge clk); #1;
    push_txn(0, 1'b0, 8'h07, '0);
    push_txn(1, 1'b0, 8'h08, '0);
    cyc = 0;
    @(negedge clk);
    while (cyc < 50 && gnt == '0) begin
      @(negedge clk);
      cyc++;
    end
    check("first_gnt_after_reset", gnt, 3'b001);
    wait_drain(200);

    // fin and req on requester 2 at the same edge: served once, then masked.
    base2 = gnt_count[2];
    @(posedge clk); #1;
    push_txn(2, 1'b0, 8'h09, '0);
    @(negedge clk);
    fin[2] = 1'b1; fin_given[2] = 1'b1;
    @(negedge clk);
    fin[2] = 1'b0;
    wait_drain(100);
    push_txn(2, 1'b0, 8'h0A, '0);
    repeat (10) @(negedge clk);
    check("req2_granted_once", gnt_count[2] - base2, 1);

    // Finish 0, then finish 1 during an in-flight read; expect flush and halt.
    @(negedge clk);
    fin[0] = 1'b1; fin_given[0] = 1'b1;
    @(negedge clk);
    fin[0] = 1'b0;
    @(posedge clk); #1;
    push_txn(1, 1'b0, 8'h05, '0);
    wait_gnt(1, 50);
    fin[1] = 1'b1; fin_given[1] = 1'b1;
    @(negedge clk);
    fin[1] = 1'b0;
    cyc = 0;
    while (cyc < 20 && !halted) begin
      @(negedge clk);
      cyc++;
    end
    check("halted_reached", halted, 1'b1);
    base0 = gnt_count[0];
    push_txn(0, 1'b0, 8'h01, '0);
    repeat (10) @(negedge clk);
    check("halt_no_gnt", gnt_count[0] - base0, 0);
    check("halted_stays", halted, 1'b1);
    check("gnt_q_empty", gnt_q.size(), 0);
    check("rd_q_empty", rd_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

endmodule
